// File: rtl/harris_frame_sequencer.sv
// Frame-level sequencer for the Harris corner datapath: clears the datapath, gates the
// pixel stream in, flushes the pipeline latency with zero pixels and tags each score with (x,y).
module harris_frame_sequencer #(
    parameter int LUMA_BITS  = 8,
    parameter int COORD_BITS = 16,
    parameter int PIPE_ROWS  = 4,
    parameter int PIPE_CLKS  = 22,
    parameter int BEAT_BITS  = 2*COORD_BITS+1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_start,
    input  logic [COORD_BITS-1:0] cfg_width,
    input  logic [COORD_BITS-1:0] cfg_height,
    output logic                  cfg_err,
    output logic                  busy,
    input  logic                  in_pix_valid,
    output logic                  in_pix_ready,
    input  logic [LUMA_BITS-1:0]  in_pix_data,
    output logic                  dp_reset,
    output logic [COORD_BITS-1:0] dp_row_length,
    output logic                  dp_in_valid,
    output logic [LUMA_BITS-1:0]  dp_in_data,
    output logic                  out_valid,
    output logic [COORD_BITS-1:0] out_x,
    output logic [COORD_BITS-1:0] out_y,
    output logic                  out_last,
    output logic                  frame_done
);

    // Wide enough that W*H + PIPE_ROWS*W + PIPE_CLKS can never wrap during the size check.
    localparam int CALC_BITS = ((BEAT_BITS > 2*COORD_BITS) ? BEAT_BITS : 2*COORD_BITS) + 8;
    localparam logic [COORD_BITS-1:0] MIN_DIM   = COORD_BITS'(3);
    localparam logic [COORD_BITS-1:0] COORD_ONE = COORD_BITS'(1);
    localparam logic [BEAT_BITS-1:0]  BEAT_ONE  = BEAT_BITS'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t state_reg, state_next;

    logic [COORD_BITS-1:0] w_reg, h_reg;
    logic [BEAT_BITS-1:0]  d_reg, npix_reg, nend_reg;
    logic [BEAT_BITS-1:0]  n_reg, n_next;
    logic [COORD_BITS-1:0] x_reg, y_reg;
    logic                  cfg_err_reg;

    logic [CALC_BITS-1:0]  cfg_pix, cfg_lat, cfg_end;
    logic                  cfg_size_ok, cfg_fits, cfg_ok, start_accept;
    logic                  stream_fire, flush_fire, last_pix, last_beat;
    logic                  x_at_end, y_at_end;

    // Frame geometry for the incoming command
    assign cfg_pix      = CALC_BITS'(cfg_width) * CALC_BITS'(cfg_height);
    assign cfg_lat      = CALC_BITS'(PIPE_ROWS) * CALC_BITS'(cfg_width) + CALC_BITS'(PIPE_CLKS);
    assign cfg_end      = cfg_pix + cfg_lat;
    assign cfg_fits     = ((cfg_end >> BEAT_BITS) == '0);
    assign cfg_size_ok  = (cfg_width >= MIN_DIM) && (cfg_height >= MIN_DIM);
    assign cfg_ok       = cfg_size_ok && cfg_fits;
    assign start_accept = (state_reg == S_IDLE) && cfg_start && cfg_ok;

    assign stream_fire  = in_pix_ready && in_pix_valid;
    assign dp_in_valid  = stream_fire || flush_fire;
    assign n_next       = n_reg + BEAT_ONE;
    assign last_pix     = (n_next == npix_reg);
    assign last_beat    = (n_next == nend_reg);

    // Flush beats feed zeros; stalled stream cycles also present zero data.
    for (genvar gi = 0; gi < LUMA_BITS; gi++) begin : g_pix_gate
        assign dp_in_data[gi] = in_pix_data[gi] & stream_fire;
    end

    // A datapath beat carries a real score once the pipeline latency D has been filled.
    assign out_valid = dp_in_valid && (n_reg >= d_reg);
    assign x_at_end  = (x_reg == w_reg - COORD_ONE);
    assign y_at_end  = (y_reg == h_reg - COORD_ONE);
    assign out_last  = out_valid && x_at_end && y_at_end;
    assign out_x     = x_reg;
    assign out_y     = y_reg;

    assign cfg_err       = cfg_err_reg;
    assign dp_row_length = w_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (start_accept) state_next = S_CLEAR;
            S_CLEAR:  state_next = S_STREAM;
            S_STREAM: if (stream_fire && last_pix) state_next = S_FLUSH;
            S_FLUSH:  if (last_beat) state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_pix_ready = 1'b0;
        busy         = 1'b0;
        flush_fire   = 1'b0;
        frame_done   = 1'b0;
        dp_reset     = reset;
        case (state_reg)
            S_CLEAR: begin
                busy     = 1'b1;
                dp_reset = 1'b1;
            end
            S_STREAM: begin
                busy         = 1'b1;
                in_pix_ready = 1'b1;
            end
            S_FLUSH: begin
                busy       = 1'b1;
                flush_fire = 1'b1;
            end
            S_DONE:  frame_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_reg       <= '0;
            h_reg       <= '0;
            d_reg       <= '0;
            npix_reg    <= '0;
            nend_reg    <= '0;
            n_reg       <= '0;
            x_reg       <= '0;
            y_reg       <= '0;
            cfg_err_reg <= 1'b0;
        end else begin
            cfg_err_reg <= (state_reg == S_IDLE) && cfg_start && !cfg_ok;
            if (start_accept) begin
                w_reg    <= cfg_width;
                h_reg    <= cfg_height;
                d_reg    <= cfg_lat[BEAT_BITS-1:0];
                npix_reg <= cfg_pix[BEAT_BITS-1:0];
                nend_reg <= cfg_end[BEAT_BITS-1:0];
            end
            if (state_reg == S_CLEAR) begin
                n_reg <= '0;
                x_reg <= '0;
                y_reg <= '0;
            end else begin
                if (dp_in_valid) begin
                    n_reg <= n_next;
                end
                if (out_valid) begin
                    if (x_at_end) begin
                        x_reg <= '0;
                        y_reg <= y_reg + COORD_ONE;
                    end else begin
                        x_reg <= x_reg + COORD_ONE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_harris_frame_sequencer.sv
// Bench for harris_frame_sequencer: raster-order scoreboard plus a delay-line model of
// the datapath to confirm each tagged score lines up with the right source pixel.
module tb_harris_frame_sequencer;
    localparam int LB = 8;
    localparam int CB = 16;
    localparam int PR = 4;
    localparam int PC = 22;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_start;
    logic [CB-1:0] cfg_width, cfg_height;
    logic          cfg_err, busy;
    logic          in_pix_valid, in_pix_ready;
    logic [LB-1:0] in_pix_data;
    logic          dp_reset;
    logic [CB-1:0] dp_row_length;
    logic          dp_in_valid;
    logic [LB-1:0] dp_in_data;
    logic          out_valid;
    logic [CB-1:0] out_x, out_y;
    logic          out_last, frame_done;

    always #5 clk = ~clk;

    harris_frame_sequencer #(
        .LUMA_BITS(LB), .COORD_BITS(CB), .PIPE_ROWS(PR), .PIPE_CLKS(PC), .BEAT_BITS(2*CB+1)
    ) dut (
        .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_width(cfg_width),
        .cfg_height(cfg_height), .cfg_err(cfg_err), .busy(busy),
        .in_pix_valid(in_pix_valid), .in_pix_ready(in_pix_ready), .in_pix_data(in_pix_data),
        .dp_reset(dp_reset), .dp_row_length(dp_row_length), .dp_in_valid(dp_in_valid),
        .dp_in_data(dp_in_data), .out_valid(out_valid), .out_x(out_x), .out_y(out_y),
        .out_last(out_last), .frame_done(frame_done)
    );

    typedef struct {
        int            x;
        int            y;
        bit            last;
        logic [LB-1:0] pix;
    } exp_t;

    exp_t          sb_q[$];
    logic [LB-1:0] src_q[$];
    logic [LB-1:0] hist[$];

    int total = 0, bad = 0, cyc = 0;
    int cur_d = 0, done_cnt = 0, err_cnt = 0, dpr_cnt = 0;
    int dpr_cyc = 0, first_ov_cyc = -1, last_cyc = -1, done_cyc = -1;
    int vmode = 0;
    bit alt = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every tagged score and models the datapath latency.
    always @(negedge clk) begin : monitor
        exp_t e;
        int   idx;
        if (reset) begin
            sb_q.delete();
            hist.delete();
        end else begin
            if (dp_reset) begin
                hist.delete();
                first_ov_cyc = -1;
                dpr_cyc = cyc;
                dpr_cnt++;
            end
            if (cfg_err) err_cnt++;
            if (in_pix_ready && !in_pix_valid)
                check("stall_gate", longint'(dp_in_valid), 0);
            if (busy && !in_pix_ready && dp_in_valid)
                check("flush_zero", longint'(dp_in_data), 0);
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    check("extra_beat", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    $display("beat x=%0d y=%0d last=%0d cyc=%0d", out_x, out_y, out_last, cyc);
                    check("out_x", longint'(out_x), e.x);
                    check("out_y", longint'(out_y), e.y);
                    check("out_last", longint'(out_last), longint'(e.last));
                    idx = hist.size() - cur_d;
                    if (idx >= 0) check("score_pix", longint'(hist[idx]), longint'(e.pix));
                    else check("score_early", idx, 0);
                    if (first_ov_cyc < 0) first_ov_cyc = cyc;
                    if (out_last) last_cyc = cyc;
                end
            end else if (out_last) begin
                check("last_without_valid", 1, 0);
            end
            if (dp_in_valid) hist.push_back(dp_in_data);
            if (frame_done) begin
                check("beat_count_left", sb_q.size(), 0);
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic drive_src();
        bit v;
        alt = ~alt;
        case (vmode)
            0:       v = 1'b1;
            1:       v = alt;
            default: v = ($urandom_range(0, 2) != 0);
        endcase
        in_pix_valid = (src_q.size() > 0) && v;
        in_pix_data  = (src_q.size() > 0) ? src_q[0] : LB'($urandom);
    endtask

    task automatic tick();
        bit fire;
        @(negedge clk);
        fire = in_pix_valid && in_pix_ready;
        @(posedge clk);
        #1;
        if (fire) void'(src_q.pop_front());
        cfg_start = 1'b0;
        drive_src();
    endtask

    task automatic start_frame(input int w, input int h, input int mode);
        exp_t e;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                e.x    = x;
                e.y    = y;
                e.last = (x == w-1) && (y == h-1);
                e.pix  = LB'($urandom);
                src_q.push_back(e.pix);
                sb_q.push_back(e);
            end
        end
        cur_d      = PR*w + PC;
        vmode      = mode;
        cfg_width  = CB'(w);
        cfg_height = CB'(h);
        cfg_start  = 1'b1;
        $display("frame start w=%0d h=%0d mode=%0d cyc=%0d", w, h, mode, cyc);
        drive_src();
    endtask

    task automatic wait_done(input int budget);
        int d0;
        int k;
        d0 = done_cnt;
        k = 0;
        while (done_cnt == d0 && k < budget) begin
            tick();
            k++;
        end
        check("frame_done_seen", done_cnt - d0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, longint'(busy), 0);
        check({tag, "_ready"}, longint'(in_pix_ready), 0);
        check({tag, "_dp_in_valid"}, longint'(dp_in_valid), 0);
        check({tag, "_out_valid"}, longint'(out_valid), 0);
        check({tag, "_out_last"}, longint'(out_last), 0);
        check({tag, "_frame_done"}, longint'(frame_done), 0);
        check({tag, "_cfg_err"}, longint'(cfg_err), 0);
        check({tag, "_row_len"}, longint'(dp_row_length), 0);
        check({tag, "_dp_reset"}, longint'(dp_reset), 1);
    endtask

    task automatic run_timed_4x3(input string tag);
        int c0;
        start_frame(4, 3, 0);
        c0 = cyc;
        wait_done(200);
        check({tag, "_dp_reset_cyc"}, dpr_cyc - c0, 1);
        check({tag, "_first_ov_cyc"}, first_ov_cyc - c0, 40);
        check({tag, "_last_cyc"}, last_cyc - c0, 51);
        check({tag, "_done_cyc"}, done_cyc - c0, 52);
        check({tag, "_row_len"}, longint'(dp_row_length), 4);
    endtask

    initial begin
        int c0;
        int e0;
        int d0;
        int w;
        int h;
        int m;
        reset        = 1'b1;
        cfg_start    = 1'b0;
        cfg_width    = '0;
        cfg_height   = '0;
        in_pix_valid = 1'b0;
        in_pix_data  = '0;
        repeat (3) tick();
        check_reset_outputs("reset");
        reset = 1'b0;
        repeat (2) tick();

        // Always-valid source: exact latency profile
        run_timed_4x3("timed");

        // Alternate-cycle source: same beats and order, longer stream
        start_frame(4, 3, 1);
        wait_done(300);

        // Rejected sizes
        for (int i = 0; i < 3; i++) begin
            e0 = err_cnt;
            d0 = dpr_cnt;
            w = (i == 0) ? 2 : (i == 1) ? 5 : 0;
            h = (i == 1) ? 2 : 4;
            cfg_width  = CB'(w);
            cfg_height = CB'(h);
            cfg_start  = 1'b1;
            tick();
            check("cfg_err_pulse", longint'(cfg_err), 1);
            check("cfg_err_busy", longint'(busy), 0);
            tick();
            check("cfg_err_one_cycle", longint'(cfg_err), 0);
            check("cfg_err_count", err_cnt - e0, 1);
            check("cfg_err_no_dp_reset", dpr_cnt - d0, 0);
            check("cfg_err_row_len", longint'(dp_row_length), 4);
        end

        // Second start mid-stream is ignored
        e0 = err_cnt;
        start_frame(4, 3, 1);
        repeat (6) tick();
        check("mid_in_stream", longint'(in_pix_ready), 1);
        cfg_width  = CB'(7);
        cfg_height = CB'(5);
        cfg_start  = 1'b1;
        tick();
        tick();
        check("mid_row_len", longint'(dp_row_length), 4);
        wait_done(300);
        check("mid_row_len_end", longint'(dp_row_length), 4);
        check("mid_no_cfg_err", err_cnt - e0, 0);

        // Reset during flush aborts without frame_done
        start_frame(4, 3, 0);
        c0 = cyc;
        while (cyc < c0 + 20) tick();
        check("abort_in_flush", longint'(busy && !in_pix_ready), 1);
        d0 = done_cnt;
        reset = 1'b1;
        tick();
        check_reset_outputs("abort");
        reset = 1'b0;
        src_q.delete();
        drive_src();
        repeat (60) tick();
        check("abort_no_done", done_cnt - d0, 0);
        run_timed_4x3("after_abort");

        // Randomized frames
        for (int i = 0; i < 5; i++) begin
            w = $urandom_range(3, 9);
            h = $urandom_range(3, 6);
            m = $urandom_range(0, 2);
            start_frame(w, h, m);
            wait_done(w*h*4 + PR*w + PC + 50);
            tick();
            check("rand_idle_busy", longint'(busy), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
